// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: sequencer that serialises a parallel word into a
// bidirectional D-flip-flop shift register over a programmed number of shifts.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, abort      request a sequence / cancel one in progress
//   dir, len, data_in direction (1 = right), shift count, word to serialise
//   sr_d, sr_r_l      serial bit and direction to the shift register
//   sr_en             shift enable to the shift register
//   busy, done, cnt   status: in progress, end pulse, shifts issued
module shift_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic [CNT_W-1:0] len,
    input  logic [WIDTH-1:0] data_in,
    input  logic             abort,
    output logic             sr_d,
    output logic             sr_r_l,
    output logic             sr_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_n;

    logic [WIDTH-1:0] data_q;
    logic             dir_q;
    logic [CNT_W-1:0] len_q;

    logic [CNT_W-1:0] len_eff;
    logic [CNT_W-1:0] cnt_inc;
    logic             last_shift;

    logic             sr_d_n;
    logic             sr_r_l_n;
    logic             sr_en_n;
    logic             busy_n;
    logic             done_n;
    logic [CNT_W-1:0] cnt_n;

    // Bit k of the serial stream: LSB first when shifting right, MSB first
    // when shifting left, so a full-length load leaves the word intact.
    function automatic logic pick_bit(
        input logic [WIDTH-1:0] w,
        input logic             right,
        input logic [CNT_W-1:0] k
    );
        logic [CNT_W-1:0] idx;
        logic             b;
        b = 1'b0;
        if (right)
            idx = k;
        else
            idx = CNT_W'(WIDTH - 1) - k;
        for (int i = 0; i < WIDTH; i++) begin
            if (CNT_W'(i) == idx)
                b = w[i];
        end
        return b;
    endfunction

    assign len_eff = (len == '0 || len > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : len;

    // cnt_inc is the number of shifts completed once the current edge lands.
    assign cnt_inc    = cnt + CNT_W'(1);
    assign last_shift = (cnt_inc == len_q);

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            data_q <= '0;
            dir_q  <= 1'b0;
            len_q  <= '0;
            sr_d   <= 1'b0;
            sr_r_l <= 1'b0;
            sr_en  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            cnt    <= '0;
        end else begin
            state  <= state_n;
            sr_d   <= sr_d_n;
            sr_r_l <= sr_r_l_n;
            sr_en  <= sr_en_n;
            busy   <= busy_n;
            done   <= done_n;
            cnt    <= cnt_n;
            if (state == IDLE && start) begin
                data_q <= data_in;
                dir_q  <= dir;
                len_q  <= len_eff;
            end
        end
    end

    // Next state
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (start)
                    state_n = SHIFT;
            end
            SHIFT: begin
                if (abort)
                    state_n = IDLE;
                else if (last_shift)
                    state_n = DONE;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Next output values; the first bit is driven from the live inputs so
    // the shift register sees it on the cycle right after the start edge.
    always_comb begin
        sr_d_n   = 1'b0;
        sr_r_l_n = sr_r_l;
        sr_en_n  = 1'b0;
        busy_n   = 1'b0;
        done_n   = 1'b0;
        cnt_n    = cnt;
        unique case (state)
            IDLE: begin
                if (start) begin
                    sr_d_n   = pick_bit(data_in, dir, '0);
                    sr_r_l_n = dir;
                    sr_en_n  = 1'b1;
                    busy_n   = 1'b1;
                    cnt_n    = '0;
                end
            end
            SHIFT: begin
                // The register shifts on this edge regardless of abort.
                cnt_n = cnt_inc;
                if (!abort && !last_shift) begin
                    sr_d_n  = pick_bit(data_q, dir_q, cnt_inc);
                    sr_en_n = 1'b1;
                    busy_n  = 1'b1;
                end else if (!abort) begin
                    done_n = 1'b1;
                end
            end
            DONE: begin
                done_n = 1'b0;
            end
            default: begin
                cnt_n = cnt;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: randomized and directed bench for shift_seq_ctrl with a
// schedule-based reference model and a model of the controlled shift register.
module tb_shift_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       dir;
    logic [2:0] len;
    logic [3:0] data_in;
    logic       abort;
    logic       sr_d;
    logic       sr_r_l;
    logic       sr_en;
    logic       busy;
    logic       done;
    logic [2:0] cnt;

    shift_seq_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .dir(dir),
        .len(len),
        .data_in(data_in),
        .abort(abort),
        .sr_d(sr_d),
        .sr_r_l(sr_r_l),
        .sr_en(sr_en),
        .busy(busy),
        .done(done),
        .cnt(cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Controlled 4-bit shift register (q[3]..q[0]), with a bench preload.
    logic [3:0] q;
    logic       pre_en;
    logic [3:0] pre_val;

    always @(posedge clk) begin
        if (pre_en)
            q <= pre_val;
        else if (sr_en)
            q <= sr_r_l ? {sr_d, q[3:1]} : {q[2:0], sr_d};
    end

    // Reference model: each accepted start expands into a schedule of
    // expected per-cycle output records; one record is consumed per edge.
    typedef struct packed {
        logic       en;
        logic       d;
        logic       rl;
        logic       busy;
        logic       done;
        logic [2:0] cnt;
        logic       dchk;
    } exp_t;

    exp_t sched[$];
    exp_t cur;

    function automatic int eff_len(input logic [2:0] l);
        return (l == 3'd0 || l > 3'd4) ? 4 : int'(l);
    endfunction

    always @(posedge clk) begin
        exp_t r;
        int   n;
        if (rst) begin
            sched.delete();
            cur = '0;
            cur.dchk = 1'b1;
        end else if (cur.en && abort) begin
            sched.delete();
            cur.en   = 1'b0;
            cur.busy = 1'b0;
            cur.done = 1'b0;
            cur.dchk = 1'b0;
            cur.cnt  = cur.cnt + 3'd1;
        end else if (sched.size() != 0) begin
            cur = sched.pop_front();
        end else if (cur.done) begin
            cur.done = 1'b0;
            cur.dchk = 1'b0;
        end else if (start) begin
            n = eff_len(len);
            for (int i = 0; i < n; i++) begin
                r.en   = 1'b1;
                r.d    = dir ? data_in[i] : data_in[3 - i];
                r.rl   = dir;
                r.busy = 1'b1;
                r.done = 1'b0;
                r.cnt  = 3'(i);
                r.dchk = 1'b1;
                sched.push_back(r);
            end
            r = '0;
            r.rl   = dir;
            r.done = 1'b1;
            r.cnt  = 3'(n);
            r.dchk = 1'b1;
            sched.push_back(r);
            cur = sched.pop_front();
        end
    end

    int n_chk;
    int n_fail;
    bit chk_on;

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("sr_en", 8'(sr_en), 8'(cur.en));
            check("busy", 8'(busy), 8'(cur.busy));
            check("done", 8'(done), 8'(cur.done));
            check("cnt", 8'(cnt), 8'(cur.cnt));
            check("sr_r_l", 8'(sr_r_l), 8'(cur.rl));
            if (cur.dchk)
                check("sr_d", 8'(sr_d), 8'(cur.d));
        end
    end

    logic [7:0] seqv;
    int         nsh;
    int         ndone;

    task automatic tick();
        @(negedge clk);
        if (sr_en) begin
            seqv = {seqv[6:0], sr_d};
            nsh++;
        end
        if (done)
            ndone++;
        @(posedge clk);
        #1;
    endtask

    // Start a sequence; ab_at = k aborts at the k-th edge after the start
    // edge (0 = never); hold keeps start high through SHIFT and DONE.
    task automatic run(input logic [3:0] dat, input logic dr,
                       input logic [2:0] ln, input bit hold, input int ab_at);
        bit fin;
        fin     = 1'b0;
        data_in = dat;
        dir     = dr;
        len     = ln;
        start   = 1'b1;
        nsh     = 0;
        ndone   = 0;
        seqv    = '0;
        tick();
        if (!hold)
            start = 1'b0;
        data_in = 4'($urandom);
        dir     = 1'($urandom);
        len     = 3'($urandom);
        for (int i = 1; i <= 12 && !fin; i++) begin
            abort = (i == ab_at);
            tick();
            if (ndone != 0)
                fin = 1'b1;
        end
        abort = 1'b0;
        start = 1'b0;
        if (ab_at == 0)
            check("done_seen", 8'(fin), 8'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            tick();
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        chk_on  = 1'b0;
        rst     = 1'b1;
        start   = 1'b0;
        dir     = 1'b0;
        len     = 3'd0;
        data_in = 4'd0;
        abort   = 1'b0;
        pre_en  = 1'b1;
        pre_val = 4'b1010;
        seqv    = '0;
        nsh     = 0;
        ndone   = 0;
        @(posedge clk);
        #1;
        chk_on = 1'b1;
        tick();
        tick();
        rst    = 1'b0;
        pre_en = 1'b0;
        idle(10);
        check("idle_q", 8'(q), 8'b1010);
        check("idle_busy", 8'(busy), 8'd0);
        check("idle_cnt", 8'(cnt), 8'd0);
        check("idle_shifts", 8'(nsh), 8'd0);

        // Right load, LSB first
        run(4'b1011, 1'b1, 3'd4, 1'b0, 0);
        check("right_seq", seqv, 8'b1101);
        check("right_q", 8'(q), 8'b1011);
        check("right_cnt", 8'(cnt), 8'd4);
        check("right_done", 8'(ndone), 8'd1);
        idle(2);

        // Left load, len 0 means full width
        run(4'b0110, 1'b0, 3'd0, 1'b0, 0);
        check("left_seq", seqv, 8'b0110);
        check("left_q", 8'(q), 8'b0110);
        check("left_shifts", 8'(nsh), 8'd4);
        idle(2);

        // Partial shift and clamp
        pre_en = 1'b1;
        pre_val = 4'b1111;
        tick();
        pre_en = 1'b0;
        run(4'b0000, 1'b1, 3'd2, 1'b0, 0);
        check("part_q", 8'(q), 8'b0011);
        check("part_cnt", 8'(cnt), 8'd2);
        pre_en = 1'b1;
        tick();
        pre_en = 1'b0;
        run(4'b0000, 1'b1, 3'd7, 1'b0, 0);
        check("clamp_shifts", 8'(nsh), 8'd4);
        check("clamp_q", 8'(q), 8'b0000);
        idle(2);

        // Abort after two shifts
        pre_en = 1'b1;
        tick();
        pre_en = 1'b0;
        run(4'b0000, 1'b1, 3'd4, 1'b0, 2);
        idle(3);
        check("abort_shifts", 8'(nsh), 8'd2);
        check("abort_done", 8'(ndone), 8'd0);
        check("abort_cnt", 8'(cnt), 8'd2);
        check("abort_q", 8'(q), 8'b0011);
        check("abort_busy", 8'(busy), 8'd0);

        // start held through SHIFT and DONE
        run(4'b1010, 1'b0, 3'd4, 1'b1, 0);
        idle(4);
        check("hold_shifts", 8'(nsh), 8'd4);
        check("hold_done", 8'(ndone), 8'd1);
        check("hold_q", 8'(q), 8'b1010);

        // Reset mid-sequence
        data_in = 4'b1100;
        dir     = 1'b1;
        len     = 3'd4;
        start   = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        ndone = 0;
        tick();
        rst = 1'b0;
        check("rst_busy", 8'(busy), 8'd0);
        check("rst_en", 8'(sr_en), 8'd0);
        check("rst_cnt", 8'(cnt), 8'd0);
        check("rst_rl", 8'(sr_r_l), 8'd0);
        idle(3);
        check("rst_done", 8'(ndone), 8'd0);
        run(4'b1001, 1'b1, 3'd4, 1'b0, 0);
        check("after_rst_q", 8'(q), 8'b1001);

        // Randomized sequences
        for (int t = 0; t < 40; t++) begin
            logic [3:0] dat;
            logic       dr;
            logic [2:0] ln;
            int         ab;
            bit         hold;
            int         l;
            dat  = 4'($urandom);
            dr   = 1'($urandom);
            ln   = 3'($urandom_range(0, 7));
            ab   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            hold = (ab == 0) ? 1'($urandom) : 1'b0;
            l    = eff_len(ln);
            if (ab > l)
                ab = 0;
            run(dat, dr, ln, hold, ab);
            check("rnd_shifts", 8'(nsh), 8'((ab != 0) ? ab : l));
            check("rnd_done", 8'(ndone), 8'((ab != 0) ? 0 : 1));
            if (ab == 0 && l == 4)
                check("rnd_q", 8'(q), 8'(dat));
            idle($urandom_range(0, 2));
        end

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
